// File: rtl/i2c_master_ctrl.sv
// Single-master I2C transaction sequencer: START, address+R/W, up to 15 data bytes with ACK/NACK, STOP.
// Define I2C_CLK_STRETCH_EN to let a slave stretch SCL during the high quarters of each bit.
module i2c_master_ctrl #(
    parameter int CLK_DIV = 250
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [6:0] cmd_addr,
    input  logic       cmd_read,
    input  logic [3:0] cmd_len,
    output logic       wr_req,
    input  logic [7:0] wr_data,
    output logic       rd_valid,
    output logic [7:0] rd_data,
    output logic       busy,
    output logic       done,
    output logic       nack,
    input  logic       sda_i,
    output logic       sda_oe,
    input  logic       scl_i,
    output logic       scl_oe
);
    localparam int QW = $clog2(CLK_DIV);

    localparam logic [3:0] S_IDLE     = 4'd0;
    localparam logic [3:0] S_START    = 4'd1;
    localparam logic [3:0] S_ADDR     = 4'd2;
    localparam logic [3:0] S_ADDR_ACK = 4'd3;
    localparam logic [3:0] S_WRITE    = 4'd4;
    localparam logic [3:0] S_WACK     = 4'd5;
    localparam logic [3:0] S_READ     = 4'd6;
    localparam logic [3:0] S_RACK     = 4'd7;
    localparam logic [3:0] S_STOP     = 4'd8;

    logic [3:0]    state_q, state_d;
    logic [QW-1:0] qcnt_q, qcnt_d;
    logic [1:0]    qtr_q, qtr_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic [6:0]    addr_q, addr_d;
    logic          read_q, read_d;
    logic [3:0]    len_q, len_d;
    logic          ack_q, ack_d;
    logic          nack_q, nack_d;
    logic          done_q, done_d;
    logic          rd_valid_q, rd_valid_d;
    logic [7:0]    rd_data_q, rd_data_d;

    logic stretch_hold;
    logic tick, sample_pt, bit_end, first_clk;

`ifdef I2C_CLK_STRETCH_EN
    // A slave holding SCL low during our released quarters freezes the quarter timer.
    assign stretch_hold = qtr_q[1] && !scl_i && (state_q != S_IDLE);
`else
    logic unused_scl;
    assign unused_scl   = scl_i;
    assign stretch_hold = 1'b0;
`endif

    assign tick      = (qcnt_q == QW'(CLK_DIV - 1)) && !stretch_hold;
    assign sample_pt = tick && (qtr_q == 2'd2);
    assign bit_end   = tick && (qtr_q == 2'd3);
    assign first_clk = (qtr_q == 2'd0) && (qcnt_q == '0);

    assign wr_req    = (state_q == S_WRITE) && (bit_q == 3'd0) && first_clk;
    assign cmd_ready = (state_q == S_IDLE);
    assign busy      = (state_q != S_IDLE);
    assign done      = done_q;
    assign nack      = nack_q;
    assign rd_valid  = rd_valid_q;
    assign rd_data   = rd_data_q;

    always_comb begin
        scl_oe = 1'b0;
        sda_oe = 1'b0;
        case (state_q)
            S_IDLE:  scl_oe = 1'b0;
            S_START: begin
                scl_oe = (qtr_q == 2'd3);
                sda_oe = qtr_q[1];
            end
            S_STOP: begin
                scl_oe = !qtr_q[1];
                sda_oe = (qtr_q != 2'd3);
            end
            default: scl_oe = !qtr_q[1];
        endcase
        case (state_q)
            S_ADDR:  sda_oe = !shift_q[7];
            // The byte is only loaded at the end of the wr_req clock, so stay released for it.
            S_WRITE: sda_oe = !(wr_req || shift_q[7]);
            S_RACK:  sda_oe = (len_q != 4'd0);
            default: ;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        qcnt_d     = qcnt_q;
        qtr_d      = qtr_q;
        bit_d      = bit_q;
        shift_d    = shift_q;
        addr_d     = addr_q;
        read_d     = read_q;
        len_d      = len_q;
        ack_d      = ack_q;
        nack_d     = nack_q;
        done_d     = 1'b0;
        rd_valid_d = 1'b0;
        rd_data_d  = rd_data_q;

        if (state_q != S_IDLE && !stretch_hold) begin
            if (tick) begin
                qcnt_d = '0;
                qtr_d  = qtr_q + 2'd1;
            end else begin
                qcnt_d = qcnt_q + QW'(1);
            end
        end

        case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    addr_d  = cmd_addr;
                    read_d  = cmd_read;
                    len_d   = cmd_len;
                    nack_d  = 1'b0;
                    qcnt_d  = '0;
                    qtr_d   = 2'd0;
                    bit_d   = 3'd0;
                    state_d = S_START;
                end
            end
            S_START: begin
                if (bit_end) begin
                    shift_d = {addr_q, read_q};
                    bit_d   = 3'd0;
                    state_d = S_ADDR;
                end
            end
            S_ADDR, S_WRITE: begin
                if (wr_req) shift_d = wr_data;
                if (bit_end) begin
                    shift_d = {shift_q[6:0], 1'b0};
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) state_d = (state_q == S_ADDR) ? S_ADDR_ACK : S_WACK;
                end
            end
            S_ADDR_ACK: begin
                if (sample_pt) ack_d = sda_i;
                if (bit_end) begin
                    if (ack_q) begin
                        nack_d  = 1'b1;
                        state_d = S_STOP;
                    end else if (len_q == 4'd0) state_d = S_STOP;
                    else if (read_q)            state_d = S_READ;
                    else                        state_d = S_WRITE;
                end
            end
            S_WACK: begin
                if (sample_pt) ack_d = sda_i;
                if (bit_end) begin
                    if (ack_q) begin
                        nack_d  = 1'b1;
                        state_d = S_STOP;
                    end else begin
                        len_d   = len_q - 4'd1;
                        state_d = (len_q == 4'd1) ? S_STOP : S_WRITE;
                    end
                end
            end
            S_READ: begin
                if (sample_pt) begin
                    shift_d = {shift_q[6:0], sda_i};
                    if (bit_q == 3'd7) begin
                        rd_data_d  = {shift_q[6:0], sda_i};
                        rd_valid_d = 1'b1;
                    end
                end
                if (bit_end) begin
                    bit_d = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
                        len_d   = len_q - 4'd1;
                        state_d = S_RACK;
                    end
                end
            end
            S_RACK: begin
                if (bit_end) state_d = (len_q == 4'd0) ? S_STOP : S_READ;
            end
            S_STOP: begin
                if (bit_end) begin
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            qcnt_q     <= '0;
            qtr_q      <= 2'd0;
            bit_q      <= 3'd0;
            shift_q    <= 8'd0;
            addr_q     <= 7'd0;
            read_q     <= 1'b0;
            len_q      <= 4'd0;
            ack_q      <= 1'b0;
            nack_q     <= 1'b0;
            done_q     <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= 8'd0;
        end else begin
            state_q    <= state_d;
            qcnt_q     <= qcnt_d;
            qtr_q      <= qtr_d;
            bit_q      <= bit_d;
            shift_q    <= shift_d;
            addr_q     <= addr_d;
            read_q     <= read_d;
            len_q      <= len_d;
            ack_q      <= ack_d;
            nack_q     <= nack_d;
            done_q     <= done_d;
            rd_valid_q <= rd_valid_d;
            rd_data_q  <= rd_data_d;
        end
    end
endmodule
